vga_scan_ctrl: RTL and testbench

- Scan and fetch controller that sequences the VGA output stage.
- Generates curr_x/curr_y raster counters and prefetches framebuffer pixels through a request/response memory port into a small in-order pixel FIFO.
- Presents pixel_data aligned to the current raster position, so the downstream vga output stage needs no further alignment.
- Detects and recovers from memory underflow without losing pixel alignment.

---
 rtl/vga_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_vga_scan_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl.sv
// Raster counters plus in-order framebuffer prefetch into a small pixel FIFO.
// Pixels lost to memory underflow are repaid as "debt" so later pixels stay aligned.
module vga_scan_ctrl #(
  parameter int H_DISPLAY   = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_DISPLAY   = 480,
  parameter int V_TOTAL     = 525,
  parameter int COLORS      = 3,
  parameter int COLOR_DEPTH = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_W      = 19
) (
  input  logic                          clk_25mhz,
  input  logic                          rst_n,
  input  logic                          enable,
  output logic [$clog2(H_TOTAL)-1:0]    curr_x,
  output logic [$clog2(V_TOTAL)-1:0]    curr_y,
  output logic [COLORS*COLOR_DEPTH-1:0] pixel_data,
  output logic                          frame_start,
  output logic                          fb_req,
  output logic [ADDR_W-1:0]             fb_addr,
  input  logic                          fb_ready,
  input  logic                          fb_rvalid,
  input  logic [COLORS*COLOR_DEPTH-1:0] fb_rdata,
  output logic                          underflow,
  input  logic                          underflow_clr
);
  localparam int XW    = $clog2(H_TOTAL);
  localparam int YW    = $clog2(V_TOTAL);
  localparam int PIX_W = COLORS * COLOR_DEPTH;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  localparam logic [XW-1:0]     X_VIS    = XW'(H_DISPLAY);
  localparam logic [XW-1:0]     X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0]     Y_VIS    = YW'(V_DISPLAY);
  localparam logic [YW-1:0]     Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] A_LAST   = ADDR_W'(H_DISPLAY * V_DISPLAY - 1);
  localparam logic [CW-1:0]     DEPTH    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]     DEBT_MAX = '1;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t            state, state_nxt;
  logic [PIX_W-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, outstanding, debt, debt_nxt;
  logic [CW:0]       credit, debt_eff, debt_tmp;
  logic              fetch_on, active, accept, push, pop, drop, starve;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && outstanding == '0) state_nxt = FILL;
      FILL:    if (!enable) state_nxt = IDLE;
               else if (count == DEPTH) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fetch_on = (state == FILL) || (state == RUN);
    active   = (state == RUN) && (curr_x < X_VIS) && (curr_y < Y_VIS);
    credit   = {1'b0, count} + {1'b0, outstanding};
    fb_req   = fetch_on && (credit < {1'b0, DEPTH});
    accept   = fb_req && fb_ready;
    // No bypass: an empty FIFO starves even if a word lands this cycle;
    // that word belongs to the starved pixel and is paid off as debt.
    starve   = active && (count == '0);
    pop      = active && (count != '0);
    debt_eff = {1'b0, debt} + {{CW{1'b0}}, starve};
    drop     = fb_rvalid && fetch_on && (debt_eff != '0);
    push     = fb_rvalid && fetch_on && (debt_eff == '0);
    debt_tmp = drop ? debt_eff - 1'b1 : debt_eff;
    debt_nxt = debt_tmp[CW] ? DEBT_MAX : debt_tmp[CW-1:0];
    pixel_data  = pop ? mem[rd_ptr] : '0;
    frame_start = (state == RUN) && (curr_x == '0) && (curr_y == '0);
  end

  always_ff @(posedge clk_25mhz) begin
    if (push) mem[wr_ptr] <= fb_rdata;
  end

  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      state       <= IDLE;
      curr_x      <= '0;
      curr_y      <= '0;
      fb_addr     <= '0;
      count       <= '0;
      outstanding <= '0;
      debt        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      underflow   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == RUN && state_nxt == RUN) begin
        if (curr_x == X_LAST) begin
          curr_x <= '0;
          curr_y <= (curr_y == Y_LAST) ? '0 : curr_y + 1'b1;
        end else begin
          curr_x <= curr_x + 1'b1;
        end
      end else begin
        curr_x <= '0;
        curr_y <= '0;
      end

      // Responses keep retiring across IDLE so a restart never sees stale data.
      case ({accept, fb_rvalid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
        default: ;
      endcase

      if (state_nxt == IDLE) begin
        fb_addr <= '0;
        count   <= '0;
        debt    <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
      end else begin
        if (accept) fb_addr <= (fb_addr == A_LAST) ? '0 : fb_addr + 1'b1;
        if (push)   wr_ptr  <= wr_ptr + 1'b1;
        if (pop)    rd_ptr  <= rd_ptr + 1'b1;
        count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        debt  <= debt_nxt;
      end

      if (starve)             underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed + randomized bench for vga_scan_ctrl on a reduced raster geometry,
// with an in-order latency memory model and an address-stream reference.
module tb_vga_scan_ctrl;
  localparam int HD = 160, HT = 240, VD = 4, VT = 6;
  localparam int COLORS = 3, CD = 8, FD = 8, AW = 19;
  localparam int PXW = COLORS * CD;
  localparam int FB  = HD * VD;

  logic clk_25mhz = 1'b0;
  logic rst_n = 1'b0, enable = 1'b0, fb_ready = 1'b1, fb_rvalid = 1'b0, underflow_clr = 1'b0;
  logic [PXW-1:0] fb_rdata = '0;
  logic [$clog2(HT)-1:0] curr_x;
  logic [$clog2(VT)-1:0] curr_y;
  logic [PXW-1:0] pixel_data;
  logic frame_start, fb_req, underflow;
  logic [AW-1:0] fb_addr;

  vga_scan_ctrl #(
    .H_DISPLAY(HD), .H_TOTAL(HT), .V_DISPLAY(VD), .V_TOTAL(VT),
    .COLORS(COLORS), .COLOR_DEPTH(CD), .FIFO_DEPTH(FD), .ADDR_W(AW)
  ) dut (
    .clk_25mhz(clk_25mhz), .rst_n(rst_n), .enable(enable),
    .curr_x(curr_x), .curr_y(curr_y), .pixel_data(pixel_data),
    .frame_start(frame_start), .fb_req(fb_req), .fb_addr(fb_addr),
    .fb_ready(fb_ready), .fb_rvalid(fb_rvalid), .fb_rdata(fb_rdata),
    .underflow(underflow), .underflow_clr(underflow_clr)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int tests = 0, fails = 0;
  int cyc = 0;
  int lat_fix = 2;
  bit lat_rand = 0, rdy_rand = 0;
  int rq_addr[$];
  int rq_due[$];
  int out_m = 0;
  int exp_addr = 0;
  int last_acc = -1;
  bit wrap_seen = 0, mon_en = 0, pend_uf = 0, prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lat();
    return lat_rand ? int'($urandom_range(1, 4)) : lat_fix;
  endfunction

  // One clock: memory model, address-stream check, per-cycle output checks.
  task automatic tick();
    logic acc;
    logic [AW-1:0] a;
    int lin;
    acc = fb_req & fb_ready;
    a = fb_addr;
    if (mon_en && acc === 1'b1) begin
      chk("fb_addr", a, exp_addr);
      if (last_acc == FB - 1 && a == 0) wrap_seen = 1;
      last_acc = int'(a);
      exp_addr = (exp_addr + 1) % FB;
    end
    prev_stall = (fb_req === 1'b1) && !fb_ready;
    prev_addr = a;
    @(posedge clk_25mhz); #1;
    cyc++;
    if (fb_rvalid) out_m--;
    if (acc === 1'b1) begin
      rq_addr.push_back(int'(a));
      rq_due.push_back(cyc + lat());
      out_m++;
    end
    fb_rvalid = 1'b0;
    fb_rdata = '0;
    if (rq_addr.size() > 0 && rq_due[0] <= cyc + 1) begin
      fb_rvalid = 1'b1;
      fb_rdata = PXW'(rq_addr.pop_front());
      rq_due.delete(0);
    end
    if (rdy_rand) fb_ready = (curr_x >= HD - 16) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mon_en) begin
      if (pend_uf) begin chk("uf_flag", underflow, 1); pend_uf = 0; end
      chk("credit", out_m <= FD, 1);
      if (prev_stall && fb_req === 1'b1) chk("addr_hold", fb_addr, prev_addr);
      if (curr_x < HD && curr_y < VD) begin
        lin = int'(curr_y) * HD + int'(curr_x);
        tests++;
        assert (pixel_data === PXW'(lin) || pixel_data === '0) else begin
          fails++;
          $error("FAIL pix_align: got %0h expected %0h at (%0d,%0d)", pixel_data, lin, curr_x, curr_y);
        end
        if (pixel_data === '0 && lin != 0) pend_uf = 1;
      end else begin
        chk("blank_pix", pixel_data, 0);
      end
      if (frame_start === 1'b1) chk("fs_pos", {curr_x, curr_y}, 0);
    end
  endtask

  task automatic run_to(input int x, input int y, input int budget, input string tag);
    int i = 0;
    while (!(curr_x == x && curr_y == y) && i < budget) begin tick(); i++; end
    chk({tag, "_x"}, curr_x, x);
    chk({tag, "_y"}, curr_y, y);
  endtask

  task automatic wait_fs(input int budget, input string tag);
    int i = 0;
    while (frame_start !== 1'b1 && i < budget) begin tick(); i++; end
    chk(tag, frame_start, 1);
  endtask

  initial begin
    // Reset held with enable high
    enable = 1'b1; rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_x", curr_x, 0);
    chk("rst_y", curr_y, 0);
    chk("rst_req", fb_req, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_pix", pixel_data, 0);
    chk("rst_fs", frame_start, 0);
    rst_n = 1'b1; mon_en = 1;

    // Fill then start: exactly FIFO_DEPTH requests precede the first RUN cycle
    wait_fs(60, "fs1");
    chk("fill_reqs", exp_addr, FD);
    chk("fs1_pix", pixel_data, 0);
    for (int i = 1; i <= 5; i++) begin tick(); chk("x_step", curr_x, i); end
    chk("pix_5_0", pixel_data, 5);
    chk("uf_clean", underflow, 0);

    // Starve memory for 20 cycles from x=100
    run_to(100, 0, 200, "to100");
    fb_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (curr_x == 112) chk("starve_pix", pixel_data, 0);
    end
    fb_ready = 1'b1;
    chk("uf_set", underflow, 1);
    run_to(HD, 0, 200, "blank0");
    chk("blank_pix0", pixel_data, 0);
    run_to(0, 1, 200, "line1");
    chk("pix_0_1", pixel_data, HD);
    underflow_clr = 1'b1; tick(); underflow_clr = 1'b0;
    chk("uf_clr", underflow, 0);
    tick();
    chk("uf_stay0", underflow, 0);

    // Line and frame wrap
    run_to(HT - 1, 1, 400, "xlast");
    tick();
    chk("xwrap_x", curr_x, 0);
    chk("xwrap_y", curr_y, 2);
    run_to(HT - 1, VT - 1, 2000, "ylast");
    tick();
    chk("ywrap_x", curr_x, 0);
    chk("ywrap_y", curr_y, 0);
    chk("fs2", frame_start, 1);
    chk("fs2_pix", pixel_data, 0);
    chk("addr_wrap", wrap_seen, 1);

    // Disable with three requests in flight
    lat_fix = 3;
    run_to(20, 1, 400, "dis_pos");
    for (int i = 0; i < 20 && out_m != 3; i++) tick();
    chk("out3", out_m, 3);
    enable = 1'b0; fb_ready = 1'b0;
    tick();
    fb_ready = 1'b1;
    exp_addr = 0; last_acc = -1;
    chk("dis_req", fb_req, 0);
    chk("dis_x", curr_x, 0);
    chk("dis_y", curr_y, 0);
    enable = 1'b1;
    for (int i = 0; i < 12 && out_m > 0; i++) begin
      tick();
      chk("idle_hold", fb_req, 0);
    end
    chk("drained", out_m, 0);
    wait_fs(80, "fs_re");
    chk("re_pix0", pixel_data, 0);
    tick();
    chk("re_x1", curr_x, 1);
    chk("re_pix1", pixel_data, 1);

    // Random ready / latency
    lat_rand = 1; rdy_rand = 1;
    repeat (3 * HT * VT) tick();
    rdy_rand = 0; fb_ready = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
